ttl_74148_latched: RTL and testbench

Clocked, parametrised successor to the 8-line to 3-line priority encoder: active-low request lines are captured into a pending register, filtered by a loadable mask, and the highest-index unmasked pending request is presented as an inverted binary code. An acknowledge input retires the presented request, so the block works as the request-latch and vector stage of a small interrupt controller. It keeps the classic EI_bar/EO_bar/GS_bar cascade semantics, so wider controllers can be built by chaining instances.

---
 rtl/ttl_74148_latched.sv | 110 +++++++++++
 tb/tb_ttl_74148_latched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ttl_74148_latched.sv
// ttl_74148_latched: clocked priority encoder with sticky request latch,
// loadable mask and acknowledge, keeping 74148 EI/EO/GS cascade semantics.
module ttl_74148_latched #(
    parameter int WIDTH_IN   = 8,
    parameter int WIDTH_OUT  = 3,
    parameter int LATCHED    = 1,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic                 EI_bar,
    input  logic [WIDTH_IN-1:0]  A_bar,
    input  logic                 Load_bar,
    input  logic [WIDTH_IN-1:0]  D,
    input  logic                 Ack_bar,
    output logic                 EO_bar,
    output logic                 GS_bar,
    output logic [WIDTH_OUT-1:0] Y_bar,
    output logic [WIDTH_IN-1:0]  Mask
);

    // Delays model board-level timing only; registered outputs carry none.
    if (WIDTH_IN < 2 || WIDTH_IN > (1 << WIDTH_OUT) ||
        (1 << (WIDTH_OUT - 1)) >= WIDTH_IN ||
        DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_err
        $error("ttl_74148_latched: illegal parameter combination");
    end

    logic [WIDTH_IN-1:0]  p_q, p_d;
    logic [WIDTH_IN-1:0]  m_q, m_d;
    logic [WIDTH_IN-1:0]  retire;
    logic [WIDTH_IN-1:0]  elig;
    logic [WIDTH_OUT-1:0] cur_idx;
    logic [WIDTH_OUT-1:0] win_idx;
    logic                 any_elig;
    logic                 eo_q, eo_d;
    logic                 gs_q, gs_d;
    logic [WIDTH_OUT-1:0] y_q, y_d;

    assign cur_idx = ~y_q;

    // Retire the request currently on Y_bar when acknowledged.
    always_comb begin
        retire = '0;
        if (LATCHED != 0 && !Ack_bar && !gs_q) begin
            retire[cur_idx] = 1'b1;
        end
    end

    // Next pending/mask state; new arrivals override a same-cycle retire.
    always_comb begin
        if (LATCHED != 0) begin
            p_d = (p_q & ~retire) | ~A_bar;
        end else begin
            p_d = ~A_bar;
        end
        m_d  = Load_bar ? m_q : D;
        elig = p_d & ~m_d;
    end

    // Highest-index eligible request wins.
    always_comb begin
        win_idx  = '0;
        any_elig = |elig;
        for (int i = 0; i < WIDTH_IN; i++) begin
            if (elig[i]) begin
                win_idx = WIDTH_OUT'(i);
            end
        end
    end

    // Output encoding; EI_bar gates outputs only, never the state.
    always_comb begin
        eo_d = 1'b1;
        gs_d = 1'b1;
        y_d  = '1;
        if (!EI_bar) begin
            if (any_elig) begin
                gs_d = 1'b0;
                y_d  = ~win_idx;
            end else begin
                eo_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            p_q  <= '0;
            m_q  <= '0;
            eo_q <= 1'b1;
            gs_q <= 1'b1;
            y_q  <= '1;
        end else begin
            p_q  <= p_d;
            m_q  <= m_d;
            eo_q <= eo_d;
            gs_q <= gs_d;
            y_q  <= y_d;
        end
    end

    assign EO_bar = eo_q;
    assign GS_bar = gs_q;
    assign Y_bar  = y_q;
    assign Mask   = m_q;

endmodule

// File: tb/tb_ttl_74148_latched.sv
// tb_ttl_74148_latched: directed plus random stimulus for a latched
// 8-line instance and a transparent 5-line instance against a model.
module tb_ttl_74148_latched;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] m;
        logic       eo;
        logic       gs;
        logic [2:0] ybar;
    } ms_t;

    logic       clk;
    logic       a_clr, a_ei, a_ld, a_ack;
    logic [7:0] a_a, a_d;
    logic       b_clr, b_ei, b_ld, b_ack;
    logic [4:0] b_a, b_d;

    logic       a_eo, a_gs;
    logic [2:0] a_y;
    logic [7:0] a_mask;
    logic       b_eo, b_gs;
    logic [2:0] b_y;
    logic [4:0] b_mask;

    ms_t sa, sb;
    int  n_chk = 0;
    int  n_err = 0;

    ttl_74148_latched #(
        .WIDTH_IN(8), .WIDTH_OUT(3), .LATCHED(1)
    ) u_a (
        .Clk(clk), .Clear_bar(a_clr), .EI_bar(a_ei), .A_bar(a_a),
        .Load_bar(a_ld), .D(a_d), .Ack_bar(a_ack),
        .EO_bar(a_eo), .GS_bar(a_gs), .Y_bar(a_y), .Mask(a_mask)
    );

    ttl_74148_latched #(
        .WIDTH_IN(5), .WIDTH_OUT(3), .LATCHED(0)
    ) u_b (
        .Clk(clk), .Clear_bar(b_clr), .EI_bar(b_ei), .A_bar(b_a),
        .Load_bar(b_ld), .D(b_d), .Ack_bar(b_ack),
        .EO_bar(b_eo), .GS_bar(b_gs), .Y_bar(b_y), .Mask(b_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: one clock edge of the encoder.
    function automatic ms_t mstep(ms_t s, int w, bit latched, bit clr,
                                  bit ei, logic [7:0] a, bit ld,
                                  logic [7:0] d, bit ack);
        ms_t n;
        int  best;
        int  ack_idx;
        bit  do_ack;
        n = s;
        if (!clr) begin
            n.p = 0; n.m = 0; n.eo = 1; n.gs = 1; n.ybar = 7;
            return n;
        end
        do_ack  = latched && !ack && !s.gs;
        ack_idx = 7 - int'(s.ybar);
        for (int i = 0; i < 8; i++) begin
            bit req, keep;
            req  = (i < w) && (a[i] == 1'b0);
            keep = latched && s.p[i] && !(do_ack && i == ack_idx);
            n.p[i] = req || keep;
        end
        if (!ld) n.m = d & 8'((1 << w) - 1);
        best = -1;
        for (int i = w - 1; i >= 0; i--) begin
            if (best < 0 && n.p[i] && !n.m[i]) best = i;
        end
        if (ei) begin
            n.eo = 1; n.gs = 1; n.ybar = 7;
        end else if (best < 0) begin
            n.eo = 0; n.gs = 1; n.ybar = 7;
        end else begin
            n.eo = 1; n.gs = 0; n.ybar = 3'(7 - best);
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        sa = mstep(sa, 8, 1'b1, a_clr, a_ei, a_a, a_ld, a_d, a_ack);
        sb = mstep(sb, 5, 1'b0, b_clr, b_ei, {3'b111, b_a}, b_ld,
                   {3'b000, b_d}, b_ack);
        #1;
        chk("a_model", {a_eo, a_gs, a_y, a_mask},
            {sa.eo, sa.gs, sa.ybar, sa.m});
        chk("b_model", {b_eo, b_gs, b_y, b_mask},
            {sb.eo, sb.gs, sb.ybar, sb.m[4:0]});
    endtask

    initial begin
        sa = '{p: 0, m: 0, eo: 1, gs: 1, ybar: 7};
        sb = sa;
        a_clr = 0; a_ei = 0; a_a = 8'h00; a_ld = 1; a_d = 0; a_ack = 1;
        b_clr = 0; b_ei = 0; b_a = 5'h1F; b_ld = 1; b_d = 0; b_ack = 1;
        #2;
        step();
        chk("rst", {a_eo, a_gs, a_y, a_mask}, {1'b1, 1'b1, 3'd7, 8'h00});
        a_clr = 1; b_clr = 1; a_a = 8'hFF;
        step();
        chk("idle", {a_eo, a_gs, a_y}, {1'b0, 1'b1, 3'd7});

        a_a = 8'h5F; step(); a_a = 8'hFF;
        chk("prio", {a_eo, a_gs, a_y}, {1'b1, 1'b0, 3'b000});
        a_ack = 0; step();
        chk("ack1", {a_gs, a_y}, {1'b0, 3'b010});
        step(); a_ack = 1;
        chk("ack2", {a_eo, a_gs, a_y}, {1'b0, 1'b1, 3'd7});

        a_a = 8'h5F; step(); a_a = 8'hFF;
        a_ld = 0; a_d = 8'h80; step(); a_ld = 1;
        chk("mask", {a_gs, a_y, a_mask}, {1'b0, 3'b010, 8'h80});
        a_ack = 0; step(); a_ack = 1;
        chk("mskack", {a_eo, a_gs}, {1'b0, 1'b1});
        a_ld = 0; a_d = 8'h00; step(); a_ld = 1;
        chk("unmask", {a_gs, a_y}, {1'b0, 3'b000});
        a_ack = 0; step(); a_ack = 1;

        a_a = 8'hF7; step(); a_a = 8'hFF;
        chk("req3", a_y, 3'b100);
        a_ack = 0; a_a = 8'hF7; step(); a_ack = 1; a_a = 8'hFF;
        chk("ackreq", {a_gs, a_y}, {1'b0, 3'b100});
        a_ack = 0; step(); a_ack = 1;

        a_a = 8'hFB; step(); a_a = 8'hFF;
        a_ei = 1; step();
        chk("ei_off", {a_eo, a_gs, a_y}, {1'b1, 1'b1, 3'd7});
        a_ack = 0; step(); a_ack = 1;
        chk("ei_ack", {a_eo, a_gs, a_y}, {1'b1, 1'b1, 3'd7});
        a_ei = 0; step();
        chk("ei_on", {a_gs, a_y}, {1'b0, 3'b101});

        b_a = 5'h0F; step();
        chk("b_req", {b_gs, b_y}, {1'b0, 3'b011});
        b_a = 5'h1F; step();
        chk("b_idle", {b_eo, b_gs}, {1'b0, 1'b1});
        b_a = 5'h0F; b_ack = 0; step(); step();
        chk("b_ack", {b_gs, b_y}, {1'b0, 3'b011});
        b_ack = 1; b_clr = 0; step();
        chk("b_clr", {b_eo, b_gs, b_y, b_mask}, {1'b1, 1'b1, 3'd7, 5'h00});
        b_clr = 1; step();
        chk("b_resume", b_y, 3'b011);

        for (int k = 0; k < 400; k++) begin
            a_a   = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            a_d   = 8'($urandom);
            a_ld  = ($urandom_range(9) != 0);
            a_ack = ($urandom_range(1) != 0);
            a_ei  = ($urandom_range(9) == 0);
            a_clr = ($urandom_range(29) != 0);
            b_a   = ~(5'($urandom) & 5'($urandom));
            b_d   = 5'($urandom);
            b_ld  = ($urandom_range(7) != 0);
            b_ack = ($urandom_range(1) != 0);
            b_ei  = ($urandom_range(9) == 0);
            b_clr = ($urandom_range(29) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
